// File: rtl/fitness_pkg.sv
// fitness_pkg: shared widths, limits, types and FSM states for the fitness table and selection logic.
package fitness_pkg;
    localparam int FIT_WIDTH = 10;
    localparam int POP_SIZE  = 50;
    localparam int IDX_WIDTH = 6;

    typedef logic [FIT_WIDTH-1:0] fit_t;
    typedef logic [IDX_WIDTH-1:0] idx_t;
    typedef enum logic {COLLECT, READY} state_t;

    localparam fit_t FIT_MAX  = '1;
    localparam idx_t LAST_IDX = idx_t'(POP_SIZE - 1);
    localparam logic [IDX_WIDTH:0] POP_LIM = (IDX_WIDTH + 1)'(POP_SIZE);

    // An extra bit keeps the limit exact even when POP_SIZE equals 2**IDX_WIDTH
    function automatic logic idx_bad(input idx_t i);
        return {1'b0, i} >= POP_LIM;
    endfunction
endpackage

// File: rtl/fit_min_tracker.sv
// fit_min_tracker: registered running minimum with its index; clear restores all ones / index 0.
// STRICT_MIN=1 loads only on a strictly smaller value; STRICT_MIN=0 loads whenever upd_i is set.
module fit_min_tracker
    import fitness_pkg::*;
#(
    parameter bit STRICT_MIN = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 upd_i,
    input  logic [FIT_WIDTH-1:0] val_i,
    input  logic [IDX_WIDTH-1:0] idx_i,
    output logic [FIT_WIDTH-1:0] min_o,
    output logic [IDX_WIDTH-1:0] idx_o
);
    // Hold the minimum; ties keep the earlier entry because the compare is strict
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            min_o <= FIT_MAX;
            idx_o <= '0;
        end else if (clr_i) begin
            min_o <= FIT_MAX;
            idx_o <= '0;
        end else if (upd_i && (!STRICT_MIN || val_i < min_o)) begin
            min_o <= val_i;
            idx_o <= idx_i;
        end
    end
endmodule

// File: rtl/fitness_table_select.sv
// fitness_table_select: collects one energy per individual, tracks the best, and serves binary tournaments.
// Optional runner-up tracking is enabled by defining FITNESS_TABLE_ELITE2_EN.
module fitness_table_select
    import fitness_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 fit_valid_i,
    input  logic [FIT_WIDTH-1:0] fit_energy_i,
    input  logic                 new_gen_i,
    input  logic                 sel_req_i,
    input  logic [IDX_WIDTH-1:0] sel_idx_a_i,
    input  logic [IDX_WIDTH-1:0] sel_idx_b_i,
    output logic                 gen_done_o,
    output logic                 ready_o,
    output logic [FIT_WIDTH-1:0] best_energy_o,
    output logic [IDX_WIDTH-1:0] best_idx_o,
    output logic                 sel_valid_o,
    output logic [IDX_WIDTH-1:0] sel_winner_o,
    output logic                 sel_err_o,
    output logic                 overflow_o
`ifdef FITNESS_TABLE_ELITE2_EN
    ,
    output logic [FIT_WIDTH-1:0] second_energy_o,
    output logic [IDX_WIDTH-1:0] second_idx_o
`endif
);
    fit_t   tbl [POP_SIZE];
    idx_t   wr_ptr;
    state_t state;
    logic   beat, last, sel_go, a_bad, b_bad;
    fit_t   ea, eb;

    // A beat is accepted only while collecting and never alongside a generation restart
    assign beat   = fit_valid_i && !new_gen_i && state == COLLECT;
    assign last   = wr_ptr == LAST_IDX;
    assign sel_go = sel_req_i && !new_gen_i && state == READY;
    assign a_bad  = idx_bad(sel_idx_a_i);
    assign b_bad  = idx_bad(sel_idx_b_i);
    assign ea     = tbl[a_bad ? '0 : sel_idx_a_i];
    assign eb     = tbl[b_bad ? '0 : sel_idx_b_i];

    // Energy table, written in arrival order and never reset
    always_ff @(posedge clk_i) begin
        if (beat) tbl[wr_ptr] <= fit_energy_i;
    end

    // Collection FSM with its registered status outputs
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state      <= COLLECT;
            wr_ptr     <= '0;
            ready_o    <= 1'b0;
            gen_done_o <= 1'b0;
            overflow_o <= 1'b0;
        end else if (new_gen_i) begin
            state      <= COLLECT;
            wr_ptr     <= '0;
            ready_o    <= 1'b0;
            gen_done_o <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            gen_done_o <= beat && last;
            if (beat) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (last) begin
                    state   <= READY;
                    ready_o <= 1'b1;
                end
            end
            if (fit_valid_i && state == READY) overflow_o <= 1'b1;
        end
    end

    // Tournament: an out-of-range contestant always loses, equal energies favour A
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sel_valid_o  <= 1'b0;
            sel_winner_o <= '0;
            sel_err_o    <= 1'b0;
        end else begin
            sel_valid_o <= sel_go;
            sel_err_o   <= sel_go && (a_bad || b_bad);
            if (sel_go) sel_winner_o <= (b_bad || (!a_bad && ea <= eb)) ? sel_idx_a_i : sel_idx_b_i;
        end
    end

    fit_min_tracker #(.STRICT_MIN(1'b1)) u_best (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .clr_i (new_gen_i),
        .upd_i (beat),
        .val_i (fit_energy_i),
        .idx_i (wr_ptr),
        .min_o (best_energy_o),
        .idx_o (best_idx_o)
    );

`ifdef FITNESS_TABLE_ELITE2_EN
    logic new_best;

    // A new best pushes the old best down; otherwise a smaller value replaces the runner-up
    assign new_best = fit_energy_i < best_energy_o;

    fit_min_tracker #(.STRICT_MIN(1'b0)) u_second (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .clr_i (new_gen_i),
        .upd_i (beat && (new_best || fit_energy_i < second_energy_o)),
        .val_i (new_best ? best_energy_o : fit_energy_i),
        .idx_i (new_best ? best_idx_o : wr_ptr),
        .min_o (second_energy_o),
        .idx_o (second_idx_o)
    );
`endif
endmodule

// File: tb/tb_fitness_table_select.sv
// tb_fitness_table_select: scoreboard bench for collection, best tracking, tournaments, overflow and reset.
module tb_fitness_table_select;
    logic       clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic       fit_valid_i = 1'b0;
    logic [9:0] fit_energy_i = '0;
    logic       new_gen_i = 1'b0;
    logic       sel_req_i = 1'b0;
    logic [5:0] sel_idx_a_i = '0;
    logic [5:0] sel_idx_b_i = '0;
    logic       gen_done_o, ready_o, sel_valid_o, sel_err_o, overflow_o;
    logic [9:0] best_energy_o;
    logic [5:0] best_idx_o, sel_winner_o;
`ifdef FITNESS_TABLE_ELITE2_EN
    logic [9:0] second_energy_o;
    logic [5:0] second_idx_o;
`endif

    int         vectors = 0;
    int         miscompares = 0;
    logic [9:0] en [50];
    logic [9:0] exp_best;
    logic [5:0] exp_idx;
    logic [6:0] exp_q [$];
    logic [6:0] exp_v;

    fitness_table_select dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .fit_valid_i   (fit_valid_i),
        .fit_energy_i  (fit_energy_i),
        .new_gen_i     (new_gen_i),
        .sel_req_i     (sel_req_i),
        .sel_idx_a_i   (sel_idx_a_i),
        .sel_idx_b_i   (sel_idx_b_i),
        .gen_done_o    (gen_done_o),
        .ready_o       (ready_o),
        .best_energy_o (best_energy_o),
        .best_idx_o    (best_idx_o),
        .sel_valid_o   (sel_valid_o),
        .sel_winner_o  (sel_winner_o),
        .sel_err_o     (sel_err_o),
        .overflow_o    (overflow_o)
`ifdef FITNESS_TABLE_ELITE2_EN
        ,
        .second_energy_o (second_energy_o),
        .second_idx_o    (second_idx_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard pop: every tournament response must match the oldest pending request
    always @(negedge clk_i) begin
        if (rst_n && sel_valid_o) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sel_unexpected: sel_valid_o=1 winner=%0d with no request pending", sel_winner_o);
            end else begin
                exp_v = exp_q.pop_front();
                if ({sel_err_o, sel_winner_o} !== exp_v) begin
                    miscompares++;
                    $display("FAIL sel_result: got err=%0b winner=%0d, want err=%0b winner=%0d",
                             sel_err_o, sel_winner_o, exp_v[6], exp_v[5:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference tournament: out-of-range index behaves as energy 1024
    function automatic logic [6:0] tour(input int a, input int b);
        int ea = (a < 50) ? int'(en[a]) : 1024;
        int eb = (b < 50) ? int'(en[b]) : 1024;
        logic [5:0] w = (eb < ea) ? 6'(b) : 6'(a);
        return {(a >= 50 || b >= 50), w};
    endfunction

    task automatic req(input int a, input int b, input bit expect_resp);
        sel_req_i = 1'b1;
        sel_idx_a_i = 6'(a);
        sel_idx_b_i = 6'(b);
        if (expect_resp) exp_q.push_back(tour(a, b));
        tick();
    endtask

    task automatic req_idle();
        sel_req_i = 1'b0;
        tick();
        vectors++;
        if (sel_valid_o !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sel_idle: sel_valid_o=%0b pending=%0d, want 0 and 0", sel_valid_o, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic start_gen();
        new_gen_i = 1'b1;
        tick();
        new_gen_i = 1'b0;
        vectors++;
        if ({ready_o, overflow_o, best_energy_o, best_idx_o} !== {2'b00, 10'h3ff, 6'd0}) begin
            miscompares++;
            $display("FAIL new_gen: ready=%0b ovf=%0b best=%0d idx=%0d, want 0 0 1023 0",
                     ready_o, overflow_o, best_energy_o, best_idx_o);
        end
    endtask

    // Sends en[0..49]; gen_done/ready must rise only after the 50th beat
    task automatic run_gen();
        exp_best = 10'h3ff;
        exp_idx = '0;
        for (int i = 0; i < 50; i++) begin
            if (en[i] < exp_best) begin
                exp_best = en[i];
                exp_idx = 6'(i);
            end
        end
        for (int i = 0; i < 50; i++) begin
            fit_valid_i = 1'b1;
            fit_energy_i = en[i];
            tick();
            vectors++;
            if ({gen_done_o, ready_o} !== {2{i == 49}}) begin
                miscompares++;
                $display("FAIL gen_progress: beat %0d gen_done=%0b ready=%0b, want %0b", i, gen_done_o, ready_o, i == 49);
            end
        end
        fit_valid_i = 1'b0;
        tick();
        vectors++;
        if ({gen_done_o, ready_o, best_energy_o, best_idx_o} !== {2'b01, exp_best, exp_idx}) begin
            miscompares++;
            $display("FAIL gen_full: gen_done=%0b ready=%0b best=%0d idx=%0d, want 0 1 %0d %0d",
                     gen_done_o, ready_o, best_energy_o, best_idx_o, exp_best, exp_idx);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_i);
        #1;
        vectors++;
        if ({gen_done_o, ready_o, sel_valid_o, sel_err_o, overflow_o} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %05b want 00000",
                     {gen_done_o, ready_o, sel_valid_o, sel_err_o, overflow_o});
        end
        vectors++;
        if ({best_energy_o, best_idx_o, sel_winner_o} !== {10'h3ff, 6'd0, 6'd0}) begin
            miscompares++;
            $display("FAIL reset_values: best=%0d idx=%0d winner=%0d, want 1023 0 0",
                     best_energy_o, best_idx_o, sel_winner_o);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_descending();
        for (int i = 0; i < 50; i++) en[i] = 10'(100 - i);
        run_gen();
    endtask

    task automatic test_tie();
        start_gen();
        for (int i = 0; i < 50; i++) en[i] = 10'd200;
        en[7] = 10'd30;
        en[33] = 10'd30;
        run_gen();
        req(33, 7, 1);
        req(7, 33, 1);
        req(2, 3, 1);
        req_idle();
    endtask

    task automatic test_tournament();
        start_gen();
        req(1, 2, 0);
        req_idle();
        for (int i = 0; i < 50; i++) en[i] = 10'(500 + i);
        en[3] = 10'd40;
        en[9] = 10'd12;
        run_gen();
        req(3, 9, 1);
        req_idle();
        req(9, 9, 1);
        req_idle();
        req(3, 9, 1);
        req(9, 3, 1);
        req(20, 10, 1);
        req_idle();
    endtask

    task automatic test_range();
        req(55, 4, 1);
        req(60, 61, 1);
        req(4, 50, 1);
        req(49, 63, 1);
        req_idle();
    endtask

    task automatic test_overflow();
        fit_valid_i = 1'b1;
        fit_energy_i = 10'd0;
        tick();
        fit_valid_i = 1'b0;
        tick();
        vectors++;
        if ({overflow_o, ready_o, best_energy_o, best_idx_o} !== {2'b11, exp_best, exp_idx}) begin
            miscompares++;
            $display("FAIL overflow_set: ovf=%0b ready=%0b best=%0d idx=%0d, want 1 1 %0d %0d",
                     overflow_o, ready_o, best_energy_o, best_idx_o, exp_best, exp_idx);
        end
        req(0, 9, 1);
        req(3, 0, 1);
        req_idle();
        new_gen_i = 1'b1;
        fit_valid_i = 1'b1;
        fit_energy_i = 10'd1;
        tick();
        new_gen_i = 1'b0;
        fit_valid_i = 1'b0;
        vectors++;
        if ({overflow_o, ready_o, best_energy_o} !== {2'b00, 10'h3ff}) begin
            miscompares++;
            $display("FAIL overflow_clear: ovf=%0b ready=%0b best=%0d, want 0 0 1023",
                     overflow_o, ready_o, best_energy_o);
        end
        for (int i = 0; i < 50; i++) en[i] = 10'(300 - 2 * i);
        en[40] = 10'd150;
        run_gen();
        req(0, 1, 1);
        req(49, 40, 1);
        req_idle();
    endtask

    task automatic test_reset_mid();
        start_gen();
        for (int i = 0; i < 20; i++) begin
            fit_valid_i = 1'b1;
            fit_energy_i = 10'd1;
            tick();
        end
        fit_valid_i = 1'b0;
        rst_n = 1'b0;
        tick();
        vectors++;
        if ({ready_o, gen_done_o, best_energy_o, best_idx_o} !== {2'b00, 10'h3ff, 6'd0}) begin
            miscompares++;
            $display("FAIL reset_mid: ready=%0b done=%0b best=%0d idx=%0d, want 0 0 1023 0",
                     ready_o, gen_done_o, best_energy_o, best_idx_o);
        end
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 50; i++) en[i] = 10'(400 + (i * 7) % 50);
        run_gen();
        req(0, 1, 1);
        req(7, 14, 1);
        req_idle();
    endtask

`ifdef FITNESS_TABLE_ELITE2_EN
    task automatic test_elite();
        start_gen();
        vectors++;
        if ({second_energy_o, second_idx_o} !== {10'h3ff, 6'd0}) begin
            miscompares++;
            $display("FAIL elite_clear: second=%0d idx=%0d, want 1023 0", second_energy_o, second_idx_o);
        end
        fit_valid_i = 1'b1;
        fit_energy_i = 10'd5;
        tick();
        fit_energy_i = 10'd3;
        tick();
        fit_energy_i = 10'd4;
        tick();
        fit_valid_i = 1'b0;
        tick();
        vectors++;
        if ({best_energy_o, best_idx_o, second_energy_o, second_idx_o} !== {10'd3, 6'd1, 10'd4, 6'd2}) begin
            miscompares++;
            $display("FAIL elite_values: best=%0d/%0d second=%0d/%0d, want 3/1 4/2",
                     best_energy_o, best_idx_o, second_energy_o, second_idx_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_descending();
        test_tie();
        test_tournament();
        test_range();
        test_overflow();
        test_reset_mid();
`ifdef FITNESS_TABLE_ELITE2_EN
        test_elite();
`endif
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
